mem_write_monitor: RTL
======================

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

Interface
REQ-001 Parameter PASS_ADR, default 32'h000001bc, byte address of the pass/result word (word index 0x6f).
REQ-002 Parameter PASS_DATA, default 32'h6d73e55f, value that signals a passing run when written to PASS_ADR.
REQ-003 Parameter FAIL_ADR, default 32'h000001c0, byte address whose write of any value signals failure.
REQ-004 Parameter TIMEOUT_CYCLES, default 44, number of run cycles allowed before a timeout is declared (legal range 1..65535).
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; reset asserted when low.
REQ-007 adr  input  32  core data-memory byte address.
REQ-008 writedata  input  32  core store data.
REQ-009 memwrite  input  1  core store strobe; a store is sampled on a rising edge where memwrite=1.
REQ-010 done  output  1  high in any terminal state.
REQ-011 pass  output  1  high only in PASS.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 timeout  output  1  high only in TIMEOUT.
REQ-014 status  output  2  state encoding: 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
REQ-015 wr_count  output  16  number of stores sampled in RUN, saturating.
REQ-016 cycle_count  output  16  number of rising edges spent in RUN.
REQ-017 last_adr  output  32  address of the most recent store sampled in RUN.
REQ-018 last_data  output  32  data of the most recent store sampled in RUN.

Function
REQ-019 The FSM SHALL have exactly four states, RUN, PASS, FAIL and TIMEOUT; PASS, FAIL and TIMEOUT are sticky until reset.
REQ-020 Address matching SHALL compare word addresses only (adr[31:2] against the parameter's [31:2]); adr[1:0] is ignored.
REQ-021 RUN -> PASS when a store hits PASS_ADR with writedata == PASS_DATA.
REQ-022 RUN -> FAIL when a store hits PASS_ADR with writedata != PASS_DATA, or when a store hits FAIL_ADR with any data.
REQ-023 RUN -> TIMEOUT on the edge where cycle_count == TIMEOUT_CYCLES-1 and no PASS/FAIL condition holds.
REQ-024 On that same edge, a PASS or FAIL condition SHALL take priority over TIMEOUT.
REQ-025 If PASS_ADR and FAIL_ADR are configured equal, the PASS_ADR rules (REQ-021, REQ-022) SHALL apply.
REQ-026 All outputs SHALL be registered; a terminal flag SHALL assert on the same rising edge that samples the triggering store (visible one cycle after memwrite is presented).
REQ-027 In RUN, every edge SHALL increment cycle_count by 1, including the terminating edge.
REQ-028 In RUN, every sampled store SHALL increment wr_count by 1 (saturating at 16'hffff) and SHALL load last_adr/last_data, including the terminating store.
REQ-029 In terminal states, all counters and the last_adr/last_data capture SHALL be frozen, and further stores SHALL be ignored.
REQ-030 Stores to addresses other than PASS_ADR and FAIL_ADR SHALL only update the counters and capture registers.
REQ-031 memwrite=0 SHALL leave wr_count, last_adr and last_data unchanged regardless of adr or writedata.

Reset
REQ-032 While reset is low, state = RUN, done/pass/fail/timeout = 0, status = 00, and wr_count, cycle_count, last_adr and last_data all = 0, asynchronously.
REQ-033 Reset asserted mid-run or in a terminal state SHALL return immediately to the REQ-032 values.
REQ-034 Counting SHALL begin on the first rising edge after reset deasserts.

Verification
REQ-035 Release reset, then one store adr=0x1bc, data=0x6d73e55f at cycle 10 -> pass=1, status=01, wr_count=1, cycle_count=11; state held for 20 further cycles.
REQ-036 Store adr=0x1bc, data=0x00000000 -> fail=1, status=10, last_data=0; a later store of 0x6d73e55f leaves status=10.
REQ-037 No stores for 44 cycles after reset -> timeout=1 on the 44th edge, cycle_count=44, wr_count=0.
REQ-038 Passing store presented on the 44th edge -> pass=1, timeout=0 (priority per REQ-024).
REQ-039 Three stores to adr=0x100, then adr=0x1bf with data 0x6d73e55f -> pass=1, wr_count=4, last_adr=0x1bf.
REQ-040 Assert reset asynchronously (between edges) while in PASS -> all outputs 0 immediately; after release, a store to adr=0x1c0 -> fail=1.

Source files
------------

// File: rtl/mem_write_monitor.sv
// ============================================================================
// Module   : mem_write_monitor
// Purpose  : Watches core stores for a pass/fail signature word and flags
//            PASS, FAIL or TIMEOUT. Also keeps store/cycle counters and a
//            capture of the last store.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_monitor #(
  parameter logic [31:0] PASS_ADR       = 32'h000001bc,
  parameter logic [31:0] PASS_DATA      = 32'h6d73e55f,
  parameter logic [31:0] FAIL_ADR       = 32'h000001c0,
  parameter int          TIMEOUT_CYCLES = 44
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [1:0]  status,
  output logic [15:0] wr_count,
  output logic [15:0] cycle_count,
  output logic [31:0] last_adr,
  output logic [31:0] last_data
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam logic [15:0] LAST_RUN_CYCLE = 16'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t state_next;
  logic   pass_hit;
  logic   fail_hit;

  // PASS_ADR decoding wins when both addresses are configured identically.
  assign pass_hit = memwrite && (adr[31:2] == PASS_ADR[31:2]);
  assign fail_hit = memwrite && (adr[31:2] == FAIL_ADR[31:2]) && !pass_hit;

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (pass_hit) begin
          state_next = (writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
        end else if (fail_hit) begin
          state_next = ST_FAIL;
        end else if (cycle_count == LAST_RUN_CYCLE) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      wr_count    <= 16'h0000;
      cycle_count <= 16'h0000;
      last_adr    <= 32'h0000_0000;
      last_data   <= 32'h0000_0000;
    end else begin
      state   <= state_next;
      done    <= (state_next != ST_RUN);
      pass    <= (state_next == ST_PASS);
      fail    <= (state_next == ST_FAIL);
      timeout <= (state_next == ST_TIMEOUT);
      // Counters and capture run only in RUN, including the terminating edge.
      if (state == ST_RUN) begin
        cycle_count <= cycle_count + 16'h0001;
        if (memwrite) begin
          if (wr_count != 16'hffff) begin
            wr_count <= wr_count + 16'h0001;
          end
          last_adr  <= adr;
          last_data <= writedata;
        end
      end
    end
  end

  assign status = state;

endmodule

`default_nettype wire
